// File: rtl/hex_display_arbiter_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hex_display_arbiter_if                                           |
// | Request/ack and display bus between game logic and the arbiter.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface hex_display_arbiter_if;
  logic        alert_req;
  logic [15:0] alert_data;
  logic        alert_ack;
  logic        move_req;
  logic [15:0] move_data;
  logic        move_ack;
  logic [15:0] clock_data;
  logic [3:0]  clock_mask;
  logic [15:0] digits;
  logic [3:0]  digit_en;
  logic [1:0]  source;

  modport slave (
    input  alert_req, alert_data, move_req, move_data, clock_data, clock_mask,
    output alert_ack, move_ack, digits, digit_en, source
  );

  modport master (
    output alert_req, alert_data, move_req, move_data, clock_data, clock_mask,
    input  alert_ack, move_ack, digits, digit_en, source
  );
endinterface
`default_nettype wire

// File: rtl/hex_display_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | hex_display_arbiter                                              |
// | Shares four hex digits among alert, move readout and game clock. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module hex_display_arbiter #(
  parameter int HOLD_CYCLES  = 50_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic                  clk,
  input  logic                  reset,
  hex_display_arbiter_if.slave  bus
);

  localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_RELOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_CYCLES - 1);
  localparam logic [1:0] SRC_CLOCK = 2'b00;
  localparam logic [1:0] SRC_MOVE  = 2'b01;
  localparam logic [1:0] SRC_ALERT = 2'b10;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SHOW_MOVE  = 2'd1,
    SHOW_ALERT = 2'd2
  } state_t;

  state_t               state_q,     state_d;
  logic [HOLD_W-1:0]    hold_q,      hold_d;
  logic [BLINK_W-1:0]   blink_q,     blink_d;
  logic                 visible_q,   visible_d;
  logic [15:0]          digits_q,    digits_d;
  logic [3:0]           digit_en_q,  digit_en_d;
  logic [1:0]           source_q,    source_d;
  logic                 alert_ack_q, alert_ack_d;
  logic                 move_ack_q,  move_ack_d;

  logic alert_elig;
  logic move_elig;
  logic grant_alert;
  logic grant_move;
  logic show_clock;

  // A request seen while its own ack is out belongs to the transaction just granted.
  assign alert_elig = bus.alert_req & ~alert_ack_q;
  assign move_elig  = bus.move_req  & ~move_ack_q;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    blink_d     = blink_q;
    visible_d   = visible_q;
    digits_d    = digits_q;
    digit_en_d  = digit_en_q;
    source_d    = source_q;
    alert_ack_d = 1'b0;
    move_ack_d  = 1'b0;
    grant_alert = 1'b0;
    grant_move  = 1'b0;
    show_clock  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (alert_elig)     grant_alert = 1'b1;
        else if (move_elig) grant_move  = 1'b1;
        else                show_clock  = 1'b1;
      end
      SHOW_MOVE: begin
        if (alert_elig) begin
          grant_alert = 1'b1;
        end else if (hold_q == '0) begin
          if (move_elig) grant_move = 1'b1;
          else           show_clock = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
        end
      end
      SHOW_ALERT: begin
        if (hold_q == '0) begin
          if (alert_elig)     grant_alert = 1'b1;
          else if (move_elig) grant_move  = 1'b1;
          else                show_clock  = 1'b1;
        end else begin
          hold_d = hold_q - 1'b1;
          if (blink_q == '0) begin
            visible_d  = ~visible_q;
            blink_d    = BLINK_RELOAD;
            digit_en_d = visible_q ? 4'b0000 : 4'b1111;
          end else begin
            blink_d = blink_q - 1'b1;
          end
        end
      end
      default: show_clock = 1'b1;
    endcase

    if (grant_alert) begin
      state_d     = SHOW_ALERT;
      digits_d    = bus.alert_data;
      alert_ack_d = 1'b1;
      source_d    = SRC_ALERT;
    end else if (grant_move) begin
      state_d     = SHOW_MOVE;
      digits_d    = bus.move_data;
      move_ack_d  = 1'b1;
      source_d    = SRC_MOVE;
    end else if (show_clock) begin
      state_d     = IDLE;
      digits_d    = bus.clock_data;
      digit_en_d  = bus.clock_mask;
      source_d    = SRC_CLOCK;
      hold_d      = '0;
      blink_d     = '0;
      visible_d   = 1'b1;
    end

    // Every grant restarts the hold and the blink from a visible phase.
    if (grant_alert || grant_move) begin
      hold_d     = HOLD_RELOAD;
      blink_d    = BLINK_RELOAD;
      visible_d  = 1'b1;
      digit_en_d = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      blink_q     <= '0;
      visible_q   <= 1'b1;
      digits_q    <= '0;
      digit_en_q  <= 4'b0000;
      source_q    <= SRC_CLOCK;
      alert_ack_q <= 1'b0;
      move_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      visible_q   <= visible_d;
      digits_q    <= digits_d;
      digit_en_q  <= digit_en_d;
      source_q    <= source_d;
      alert_ack_q <= alert_ack_d;
      move_ack_q  <= move_ack_d;
    end
  end

  assign bus.digits    = digits_q;
  assign bus.digit_en  = digit_en_q;
  assign bus.source    = source_q;
  assign bus.alert_ack = alert_ack_q;
  assign bus.move_ack  = move_ack_q;

endmodule
`default_nettype wire
